semaforo_sequenciador: RTL
==========================

Name: semaforo_sequenciador

Overview:
- Timed lamp sequencer for the 3-road intersection, directly downstream of the combinational 3-road green-selection decoder.
- Consumes the decoder's one-hot green request ({VDC,VDB,VDA}) and drives the physical lamps.
- Inserts minimum green, yellow and all-red clearance intervals, so a request change never switches greens instantly.
- Guarantees at most one road is non-red at any time.

Parameters:
- T_MIN_GREEN, 8, minimum green duration in clock cycles (>=1)
- T_YELLOW, 3, yellow duration in clock cycles (>=1)
- T_ALL_RED, 2, all-red clearance duration in clock cycles (>=1)
- CNT_W, 8, phase counter width; must hold max(T_*)

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_green  input  3  one-hot green request from decoder, bit0=A, bit1=B, bit2=C
- VDA,VDB,VDC  output  1 each  green lamp of road A/B/C
- VAA,VAB,VAC  output  1 each  yellow lamp of road A/B/C
- VMA,VMB,VMC  output  1 each  red lamp of road A/B/C
- cur_road  output  2  road currently owning green/yellow (0=A,1=B,2=C); next target during ALL_RED

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high.
- Reset values:
  - state=ALL_RED, cnt=0, cur_road=0 (target A).
  - VMA=VMB=VMC=1; all green and yellow lamps 0.
- Outputs: Moore outputs decoded from registered state and cur_road only, with no combinational path from req_green.
- Lamp rule: every road has exactly one lamp lit in every cycle.
- Valid request: req_green has exactly one bit set. Values 000, 011, 101, 110 and 111 are invalid and are treated as "no change".
- Counter: cnt clears on every state entry and increments each cycle in the state, saturating at all-ones.
- States:
  - ALL_RED: all red. When cnt==T_ALL_RED-1, go to GREEN with road=cur_road. Lasts exactly T_ALL_RED cycles.
  - GREEN: road cur_road green, others red.
    - Leave when cnt>=T_MIN_GREEN-1, req_green is valid and it selects a road != cur_road.
    - Then go to YELLOW and latch the requested road into next_road (internal register).
    - Otherwise stay, indefinitely if the request is unchanged or invalid.
  - YELLOW: road cur_road yellow, others red. When cnt==T_YELLOW-1, go to ALL_RED and load cur_road<=next_road. Lasts exactly T_YELLOW cycles.
- Latency:
  - A qualifying request change is sampled on edge k, and yellow is visible after edge k.
  - The new green appears T_YELLOW+T_ALL_RED cycles after yellow starts.
- req_green during YELLOW/ALL_RED is ignored. next_road is committed, even if the request reverts or is invalid.
- A request equal to the current road while in GREEN causes no action.
- Reset asserted mid-phase forces all-red immediately (asynchronously). After release the sequence restarts from ALL_RED, targeting A.
- Parameters equal to 1 are legal and give single-cycle phases.

Decomposition:
- Package semaforo_pkg:
  - typedef enum state_t {ALL_RED, GREEN, YELLOW}.
  - typedef enum logic[1:0] road_t {ROAD_A, ROAD_B, ROAD_C}.
  - Function onehot_to_road returning {valid, road_t}.
- Sub-module temporizador_fase:
  - Clear/increment saturating counter (clock, reset, clr, cnt).
  - Instantiated once. The FSM compares its output against the T_* parameters.

Test Plan:
- Params 4/2/1, req=001 held, release reset → all red for 1 cycle, then VDA=1, VMB=VMC=1, steady for 20 cycles.
- Green A for 10 cycles, req→010 → next cycle VAA=1 for 2 cycles, all red for 1 cycle, then VDB=1 and cur_road=1.
- Green B entered, req→100 after 1 cycle → green B lasts exactly 4 cycles total before VAB=1; then C green after 3 more cycles.
- In green A, req cycles through 000, 011, 111 and 001 → no lamp change; exactly one lamp per road every cycle (assertion).
- Yellow A toward B, req reverts to 001 → sequence completes to green B; A is re-requested later with a normal yellow/all-red cycle.
- Reset pulse in the middle of YELLOW → all red immediately without a clock edge; after release, all red for T_ALL_RED cycles, then green A.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the three-road lamp sequencer.
// Phase and road encodings live here so the top and the bench agree on names.
package semaforo_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ROAD_A = 2'd0,
        ROAD_B = 2'd1,
        ROAD_C = 2'd2
    } road_t;

    typedef struct packed {
        logic  valid;
        road_t road;
    } road_req_t;

    // Anything that is not exactly one bit set is reported as invalid.
    function automatic road_req_t onehot_to_road(input logic [2:0] onehot);
        road_req_t r;
        r.valid = 1'b0;
        r.road  = ROAD_A;
        case (onehot)
            3'b001: begin r.valid = 1'b1; r.road = ROAD_A; end
            3'b010: begin r.valid = 1'b1; r.road = ROAD_B; end
            3'b100: begin r.valid = 1'b1; r.road = ROAD_C; end
            default: begin r.valid = 1'b0; r.road = ROAD_A; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Phase timer: clears on request, otherwise counts up and holds at all-ones.
module temporizador_fase #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Saturation keeps an indefinitely long green from wrapping back below the minimum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/semaforo_sequenciador.sv
// Timed lamp sequencer: turns the decoder's one-hot green request into
// green/yellow/all-red phases with minimum durations, one non-red road at most.
module semaforo_sequenciador
    import semaforo_pkg::*;
#(
    parameter int T_MIN_GREEN = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req_green,
    output logic       VDA,
    output logic       VDB,
    output logic       VDC,
    output logic       VAA,
    output logic       VAB,
    output logic       VAC,
    output logic       VMA,
    output logic       VMB,
    output logic       VMC,
    output logic [1:0] cur_road
);

    localparam logic [CNT_W-1:0] LAST_GREEN  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] LAST_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_RED    = CNT_W'(T_ALL_RED - 1);

    state_t           state;
    state_t           state_nxt;
    road_t            road_q;
    road_t            road_nxt;
    road_t            next_road;
    road_t            next_road_nxt;
    road_req_t        req;
    logic [CNT_W-1:0] cnt;
    logic             clr;
    logic [2:0]       road_bit;
    logic [2:0]       green;
    logic [2:0]       yellow;
    logic [2:0]       red;

    assign clr = (state_nxt != state);

    temporizador_fase #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .cnt   (cnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ALL_RED;
            road_q    <= ROAD_A;
            next_road <= ROAD_A;
        end else begin
            state     <= state_nxt;
            road_q    <= road_nxt;
            next_road <= next_road_nxt;
        end
    end

    // The request only matters in GREEN; once the target is latched it is committed.
    always_comb begin
        state_nxt     = state;
        road_nxt      = road_q;
        next_road_nxt = next_road;
        req           = onehot_to_road(req_green);
        case (state)
            ALL_RED: begin
                if (cnt == LAST_RED) begin
                    state_nxt = GREEN;
                end
            end
            GREEN: begin
                if ((cnt >= LAST_GREEN) && req.valid && (req.road != road_q)) begin
                    state_nxt     = YELLOW;
                    next_road_nxt = req.road;
                end
            end
            YELLOW: begin
                if (cnt == LAST_YELLOW) begin
                    state_nxt = ALL_RED;
                    road_nxt  = next_road;
                end
            end
            default: begin
                state_nxt = ALL_RED;
            end
        endcase
    end

    // Lamps depend only on registered state, so req_green never reaches them combinationally.
    always_comb begin
        road_bit = 3'b000;
        case (road_q)
            ROAD_A:  road_bit = 3'b001;
            ROAD_B:  road_bit = 3'b010;
            ROAD_C:  road_bit = 3'b100;
            default: road_bit = 3'b000;
        endcase
        green  = (state == GREEN)  ? road_bit : 3'b000;
        yellow = (state == YELLOW) ? road_bit : 3'b000;
        red    = ~(green | yellow);
    end

    assign {VDC, VDB, VDA} = green;
    assign {VAC, VAB, VAA} = yellow;
    assign {VMC, VMB, VMA} = red;
    assign cur_road        = road_q;

endmodule
